// File: rtl/fpga_rst_seq_pkg.sv
// fpga_rst_seq_pkg
// Shared definitions for the FPGA reset sequencer: sequencer state encodings,
// reset-cause encodings and the counter-width helper.
// Used by fpga_reset_sequencer and rst_seq_debounce.
package fpga_rst_seq_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    // Sequencer states, in release order.
    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_STAGGER   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    // Reset-cause codes reported on rst_cause_o.
    localparam logic [1:0] CAUSE_POWER_ON  = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON    = 2'b01;
    localparam logic [1:0] CAUSE_ALERT     = 2'b10;
    localparam logic [1:0] CAUSE_LOCK_LOSS = 2'b11;

    // Width of a counter that runs 0 .. cycles-1; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// rst_seq_debounce
// Two-flop synchronizer followed by a debouncer for an asynchronous level.
// The debounced output only follows the synchronized input once the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, clears synchronizer and debounce state
//   raw_i  - asynchronous raw input
//   deb_o  - debounced, synchronized level
module rst_seq_debounce
    import fpga_rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            // The last disagreeing cycle flips the output and rearms the count.
            if (cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/fpga_reset_sequencer.sv
// fpga_reset_sequencer
// Board-level reset sequencer. Waits for clock lock, holds everything in reset
// for HOLD_CYCLES (extended while the reset button is held), releases the JTAG
// TAP reset, then JTAG_LEAD cycles later releases the SoC reset. While running,
// lock loss or a button press (and, when RST_SEQ_ALERT_RESET_EN is defined, a
// monitor alert) restarts the sequence and records the cause.
// Build option: RST_SEQ_ALERT_RESET_EN - alert_i high in S_RUN becomes a reset
// event with cause 10; when undefined alert_i is ignored.
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset
//   btn_reset_i  - raw push-button, asynchronous, active-high
//   clk_locked_i - clock-generator lock, asynchronous
//   alert_i      - monitor alert level, synchronous to clk_i
//   soc_rst_no   - SoC reset, active-low, registered
//   jtag_trst_no - JTAG TAP reset, active-low, registered
//   running_o    - high only in S_RUN
//   rst_cause_o  - last reset cause (00 power-on, 01 button, 10 alert, 11 lock loss)
//   rst_count_o  - resets since rst_i, saturating at 255
//   dbg_state_o  - current sequencer state (S_* encodings in fpga_rst_seq_pkg)
module fpga_reset_sequencer
    import fpga_rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 256,
    parameter int JTAG_LEAD       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btn_reset_i,
    input  logic               clk_locked_i,
    input  logic               alert_i,
    output logic               soc_rst_no,
    output logic               jtag_trst_no,
    output logic               running_o,
    output logic [1:0]         rst_cause_o,
    output logic [7:0]         rst_count_o,
    output logic [STATE_W-1:0] dbg_state_o
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int LEAD_W = cnt_width(JTAG_LEAD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(JTAG_LEAD - 1);

    logic btn_deb;
    logic alert_evt;

    rst_seq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .raw_i (btn_reset_i),
        .deb_o (btn_deb)
    );

`ifdef RST_SEQ_ALERT_RESET_EN
    assign alert_evt = alert_i;
`else
    logic alert_unused;
    assign alert_evt    = 1'b0;
    assign alert_unused = alert_i;
`endif

    logic              lock_sync1_q, lock_sync1_d;
    logic              lock_sync2_q, lock_sync2_d;
    logic              btn_prev_q, btn_prev_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LEAD_W-1:0] lead_cnt_q, lead_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        count_q, count_d;
    logic              jtag_n_q, jtag_n_d;
    logic              soc_n_q, soc_n_d;

    logic lock_lost;
    logic btn_rise;

    assign lock_lost = ~lock_sync2_q;
    assign btn_rise  = btn_deb & ~btn_prev_q;

    always_comb begin
        lock_sync1_d = clk_locked_i;
        lock_sync2_d = lock_sync1_q;
        btn_prev_d   = btn_deb;
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        lead_cnt_d   = lead_cnt_q;
        cause_d      = cause_q;
        count_d      = count_q;

        case (state_q)
            S_WAIT_LOCK: begin
                hold_cnt_d = '0;
                lead_cnt_d = '0;
                if (!lock_lost) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (lock_lost) begin
                    state_d    = S_WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (btn_deb) begin
                    // A held button stretches the hold phase from scratch.
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_STAGGER;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_STAGGER: begin
                if (lock_lost) begin
                    state_d    = S_WAIT_LOCK;
                    lead_cnt_d = '0;
                end else if (lead_cnt_q == LEAD_LAST) begin
                    state_d    = S_RUN;
                    lead_cnt_d = '0;
                end else begin
                    lead_cnt_d = lead_cnt_q + LEAD_W'(1);
                end
            end
            S_RUN: begin
                if (lock_lost || btn_rise || alert_evt) begin
                    state_d = S_WAIT_LOCK;
                    // Simultaneous events: lock loss wins, then button, then alert.
                    if (lock_lost) begin
                        cause_d = CAUSE_LOCK_LOSS;
                    end else if (btn_rise) begin
                        cause_d = CAUSE_BUTTON;
                    end else begin
                        cause_d = CAUSE_ALERT;
                    end
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        jtag_n_d = (state_d == S_STAGGER) || (state_d == S_RUN);
        soc_n_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync1_q <= 1'b0;
            lock_sync2_q <= 1'b0;
            btn_prev_q   <= 1'b0;
            state_q      <= S_WAIT_LOCK;
            hold_cnt_q   <= '0;
            lead_cnt_q   <= '0;
            cause_q      <= CAUSE_POWER_ON;
            count_q      <= 8'd0;
            jtag_n_q     <= 1'b0;
            soc_n_q      <= 1'b0;
        end else begin
            lock_sync1_q <= lock_sync1_d;
            lock_sync2_q <= lock_sync2_d;
            btn_prev_q   <= btn_prev_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            lead_cnt_q   <= lead_cnt_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
            jtag_n_q     <= jtag_n_d;
            soc_n_q      <= soc_n_d;
        end
    end

    assign soc_rst_no   = soc_n_q;
    assign jtag_trst_no = jtag_n_q;
    assign running_o    = (state_q == S_RUN);
    assign rst_cause_o  = cause_q;
    assign rst_count_o  = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/fpga_reset_sequencer.md
FPGA_RESET_SEQUENCER -- requirements
Module: fpga_reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles before the debounced button changes.
REQ-002 SHALL have parameter HOLD_CYCLES, default 256: cycles spent in S_HOLD before JTAG reset release.
REQ-003 SHALL have parameter JTAG_LEAD, default 16: cycles between jtag_trst_no release and soc_rst_no release.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port btn_reset_i, input, 1 bit: raw push-button, asynchronous, active-high.
REQ-007 SHALL have port clk_locked_i, input, 1 bit: clock-generator lock, asynchronous.
REQ-008 SHALL have port alert_i, input, 1 bit: monitor alert level, synchronous to clk_i.
REQ-009 SHALL have port soc_rst_no, output, 1 bit: SoC reset, active-low, registered.
REQ-010 SHALL have port jtag_trst_no, output, 1 bit: JTAG TAP reset, active-low, registered.
REQ-011 SHALL have port running_o, output, 1 bit: high only in S_RUN.
REQ-012 SHALL have port rst_cause_o, output, 2 bits: last reset cause (00 power-on, 01 button, 10 alert, 11 lock loss).
REQ-013 SHALL have port rst_count_o, output, 8 bits: count of resets since rst_i, saturating at 255.

Function
REQ-014 SHALL pass btn_reset_i and clk_locked_i through 2-flop synchronizers each.
REQ-015 SHALL change the debounced button only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-016 SHALL implement the FSM S_WAIT_LOCK -> S_HOLD (synchronized lock high) -> S_STAGGER (HOLD_CYCLES elapsed) -> S_RUN (JTAG_LEAD elapsed).
REQ-017 SHALL hold the S_HOLD counter at 0 and stay in S_HOLD while the debounced button is high.
REQ-018 SHALL return from any state other than S_WAIT_LOCK to S_WAIT_LOCK on synchronized lock low, with counters cleared.
REQ-019 SHALL go from S_RUN to S_WAIT_LOCK on a debounced-button rising edge or on lock loss.
REQ-020 SHALL, with simultaneous events in S_RUN, record the cause with priority lock loss > button > alert.
REQ-021 SHALL update rst_cause_o and increment rst_count_o on the S_RUN exit cycle only.
REQ-022 SHALL drive jtag_trst_no high from the first cycle of S_STAGGER through S_RUN, and low otherwise.
REQ-023 SHALL drive soc_rst_no high only in S_RUN, so that it never releases before jtag_trst_no.
REQ-024 SHALL compute counter widths with $clog2 of their parameter, with a minimum width of 1.

Reset
REQ-025 SHALL, on rst_i, enter S_WAIT_LOCK with soc_rst_no=0, jtag_trst_no=0, running_o=0, rst_cause_o=00, rst_count_o=0, synchronizers and debounce state cleared.
REQ-026 SHALL treat rst_i asserted mid-sequence identically, discarding all in-progress counts.

Configuration
REQ-027 SHALL, with macro RST_SEQ_ALERT_RESET_EN defined, treat alert_i high in S_RUN as a reset event with cause 10.
REQ-028 SHALL, without RST_SEQ_ALERT_RESET_EN, ignore alert_i entirely, so cause 10 never occurs.

Structure
REQ-029 SHALL take the FSM state enum and the 2-bit cause encodings from package fpga_rst_seq_pkg.
REQ-030 SHALL place the synchronizer and debouncer in sub-module rst_seq_debounce, instantiated once for the button.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, JTAG_LEAD=2)
REQ-031 SHALL verify power-up: rst_i low and clk_locked_i rising at cycle 0 -> S_HOLD at cycle 3, jtag_trst_no=1 at cycle 11, soc_rst_no=1 and running_o=1 at cycle 13, rst_cause_o=00.
REQ-032 SHALL verify button bounce: a 3-cycle pulse -> no effect; a 6-cycle pulse in S_RUN -> S_WAIT_LOCK, rst_cause_o=01, rst_count_o=1.
REQ-033 SHALL verify button held in S_HOLD for 20 cycles -> jtag_trst_no stays 0 until 8 cycles after the debounced release.
REQ-034 SHALL verify lock loss and button edge in the same cycle in S_RUN -> rst_cause_o=11, rst_count_o incremented once.
REQ-035 SHALL verify alert_i=1 for 1 cycle in S_RUN -> macro defined: outputs low, cause=10; macro undefined: running_o stays 1.
REQ-036 SHALL verify saturation: 300 button resets -> rst_count_o=255; then rst_i -> all outputs at reset values next cycle.
